// File: rtl/sbp_update_sched.sv
// Front-end scheduler for the pipelined lookup: admits lookups into stage 0 and
// applies buffered RAM update batches only after in-flight lookups have drained.
module sbp_update_sched #(
    parameter int NUM_STAGES    = 32,
    parameter int ADDR_BITS     = 11,
    parameter int DATA_BITS     = 64,
    parameter int STAGE_ID_BITS = 6,
    parameter int FIFO_DEPTH    = 16,
    parameter int PIPE_LATENCY  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lkp_valid_i,
    input  logic [31:0]              lkp_ip_i,
    output logic                     lkp_ready_o,
    output logic                     ip_valid_o,
    output logic [31:0]              ip_addr_o,
    input  logic                     cmd_valid_i,
    input  logic [STAGE_ID_BITS-1:0] cmd_stage_i,
    input  logic [ADDR_BITS-1:0]     cmd_addr_i,
    input  logic [DATA_BITS-1:0]     cmd_data_i,
    input  logic                     cmd_last_i,
    output logic                     cmd_ready_o,
    output logic [NUM_STAGES-1:0]    wr_en_o,
    output logic [ADDR_BITS-1:0]     wr_addr_o,
    output logic [DATA_BITS-1:0]     wr_data_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [1:0]               dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends combinationally on valid.

    localparam int ENTRY_W = STAGE_ID_BITS + ADDR_BITS + DATA_BITS + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int IDLE_W  = $clog2(PIPE_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   pending_q, pending_d;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   lkp_ready_q, lkp_ready_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   ip_valid_q, ip_valid_d;
    logic [31:0]            ip_addr_q, ip_addr_d;
    logic [NUM_STAGES-1:0]  wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0]   wr_data_q, wr_data_d;
    logic                   err_q, err_d;

    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];

    logic                   push;
    logic                   pop;
    logic                   lkp_accept;
    logic [ENTRY_W-1:0]     head;
    logic [STAGE_ID_BITS-1:0] head_stage;
    logic [ADDR_BITS-1:0]   head_addr;
    logic [DATA_BITS-1:0]   head_data;
    logic                   head_last;

    assign push       = cmd_valid_i && cmd_ready_q;
    assign lkp_accept = lkp_valid_i && lkp_ready_q;
    assign pop        = (state_q == ST_WRITE) && (count_q != '0);

    assign head       = mem_q[rd_ptr_q];
    assign head_stage = head[ENTRY_W-1 -: STAGE_ID_BITS];
    assign head_addr  = head[DATA_BITS+ADDR_BITS -: ADDR_BITS];
    assign head_data  = head[DATA_BITS:1];
    assign head_last  = head[0];

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        err_d      = 1'b0;
        wr_en_d    = '0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        ip_valid_d = lkp_accept;
        ip_addr_d  = lkp_accept ? lkp_ip_i : ip_addr_q;

        if (ip_valid_q) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q >= IDLE_W'(PIPE_LATENCY)) begin
            idle_cnt_d = idle_cnt_q;
        end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (push && cmd_last_i) begin
                    pending_d = 1'b1;
                end else if (push && count_q == CNT_W'(FIFO_DEPTH - 1)) begin
                    // Full without a commit: force the partial batch out and flag it.
                    pending_d = 1'b1;
                    err_d     = 1'b1;
                end
                if (pending_d) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A lookup accepted alongside the commit is still in ip_valid_q here.
                if (!ip_valid_q && idle_cnt_q >= IDLE_W'(PIPE_LATENCY)) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (pop) begin
                    wr_addr_d = head_addr;
                    wr_data_d = head_data;
                    if (32'(head_stage) < NUM_STAGES) begin
                        wr_en_d = {{(NUM_STAGES-1){1'b0}}, 1'b1} << head_stage;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (head_last || count_q == CNT_W'(1)) begin
                        pending_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    pending_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
            end
        endcase

        lkp_ready_d = (state_d == ST_IDLE) && !pending_d;
        cmd_ready_d = (state_d == ST_IDLE) && !pending_d && (count_d != CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            idle_cnt_q  <= IDLE_W'(PIPE_LATENCY);
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lkp_ready_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            ip_valid_q  <= 1'b0;
            ip_addr_q   <= '0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            idle_cnt_q  <= idle_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lkp_ready_q <= lkp_ready_d;
            cmd_ready_q <= cmd_ready_d;
            ip_valid_q  <= ip_valid_d;
            ip_addr_q   <= ip_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_stage_i, cmd_addr_i, cmd_data_i, cmd_last_i};
        end
    end

    assign lkp_ready_o = lkp_ready_q;
    assign cmd_ready_o = cmd_ready_q;
    assign ip_valid_o  = ip_valid_q;
    assign ip_addr_o   = ip_addr_q;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q == ST_DRAIN) || (state_q == ST_WRITE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sbp_update_sched.sv
// Directed, table-driven bench for sbp_update_sched: lookup path, drain timing,
// batch writes, overflow, bad stage ids and reset during a write batch.
module tb_sbp_update_sched;

  localparam int NS = 32;
  localparam int PL = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lkp_valid_i = 1'b0;
  logic [31:0] lkp_ip_i = '0;
  logic        lkp_ready_o;
  logic        ip_valid_o;
  logic [31:0] ip_addr_o;
  logic        cmd_valid_i = 1'b0;
  logic [5:0]  cmd_stage_i = '0;
  logic [10:0] cmd_addr_i = '0;
  logic [63:0] cmd_data_i = '0;
  logic        cmd_last_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] wr_en_o;
  logic [10:0] wr_addr_o;
  logic [63:0] wr_data_o;
  logic        busy_o;
  logic        err_o;
  logic [1:0]  dbg_state_o;

  sbp_update_sched dut (
    .clk(clk), .rst(rst),
    .lkp_valid_i(lkp_valid_i), .lkp_ip_i(lkp_ip_i), .lkp_ready_o(lkp_ready_o),
    .ip_valid_o(ip_valid_o), .ip_addr_o(ip_addr_o),
    .cmd_valid_i(cmd_valid_i), .cmd_stage_i(cmd_stage_i), .cmd_addr_i(cmd_addr_i),
    .cmd_data_i(cmd_data_i), .cmd_last_i(cmd_last_i), .cmd_ready_o(cmd_ready_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        lkp_valid;
    logic [31:0] lkp_ip;
    logic        exp_valid;
    logic [31:0] exp_addr;
  } lkp_vec_t;

  typedef struct {
    logic [5:0]  stage;
    logic [10:0] addr;
    logic [63:0] data;
    logic        last;
    logic [31:0] exp_en;
    logic        exp_err;
    logic        exp_busy;
  } cmd_vec_t;

  lkp_vec_t lvec[6];
  cmd_vec_t cvec[13];
  logic [42:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: push table entries back-to-back
  task automatic push_cmds(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      cmd_valid_i = 1'b1;
      cmd_stage_i = cvec[i].stage;
      cmd_addr_i  = cvec[i].addr;
      cmd_data_i  = cvec[i].data;
      cmd_last_i  = cvec[i].last;
      chk("cmd_ready_before_push", cmd_ready_o, 1);
      step();
    end
    cmd_valid_i = 1'b0;
    cmd_last_i  = 1'b0;
  endtask

  task automatic wait_beat();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (wr_en_o != '0 || err_o) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("beat_timeout", seen, 1);
  endtask

  // assumes the first beat is currently visible
  task automatic check_beats(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      chk("beat_wr_en", wr_en_o, cvec[i].exp_en);
      chk("beat_err", err_o, cvec[i].exp_err);
      chk("beat_busy", busy_o, cvec[i].exp_busy);
      chk("beat_no_lookup", ip_valid_o, 0);
      if (cvec[i].exp_en != '0) begin
        chk("beat_addr", wr_addr_o, cvec[i].addr);
        chk("beat_data", wr_data_o, cvec[i].data);
      end
      if (i < first + n - 1) step();
    end
  endtask

  initial begin
    int cyc;
    int beat;
    int early;
    int errs;
    int beats;
    int stray;
    logic [5:0] stg;

    lvec[0] = '{1'b1, 32'h0A000001, 1'b1, 32'h0A000001};
    lvec[1] = '{1'b1, 32'h0A000002, 1'b1, 32'h0A000002};
    lvec[2] = '{1'b1, 32'h0A000003, 1'b1, 32'h0A000003};
    lvec[3] = '{1'b0, 32'hFFFFFFFF, 1'b0, 32'h0A000003};
    lvec[4] = '{1'b1, 32'hC0A80001, 1'b1, 32'hC0A80001};
    lvec[5] = '{1'b0, 32'h00000000, 1'b0, 32'hC0A80001};

    cvec[0]  = '{6'd0,  11'h010, 64'h1111_0000_0000_0000, 1'b0, 32'h0000_0001, 1'b0, 1'b1};
    cvec[1]  = '{6'd1,  11'h020, 64'h2222_0000_0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b1};
    cvec[2]  = '{6'd31, 11'h7FF, 64'h3333_0000_0000_0002, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    cvec[3]  = '{6'd2,  11'h000, 64'h4444_0000_0000_0003, 1'b1, 32'h0000_0004, 1'b0, 1'b0};
    cvec[4]  = '{6'd3,  11'h031, 64'hAAAA_0000_0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b1};
    cvec[5]  = '{6'd40, 11'h032, 64'hBBBB_0000_0000_0004, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    cvec[6]  = '{6'd7,  11'h033, 64'hCCCC_0000_0000_0005, 1'b1, 32'h0000_0080, 1'b0, 1'b0};
    cvec[7]  = '{6'd10, 11'h100, 64'h0000_0000_0000_0A0A, 1'b0, 32'h0000_0400, 1'b0, 1'b1};
    cvec[8]  = '{6'd11, 11'h101, 64'h0000_0000_0000_0B0B, 1'b0, 32'h0000_0800, 1'b0, 1'b1};
    cvec[9]  = '{6'd12, 11'h102, 64'h0000_0000_0000_0C0C, 1'b0, 32'h0000_1000, 1'b0, 1'b1};
    cvec[10] = '{6'd13, 11'h103, 64'h0000_0000_0000_0D0D, 1'b0, 32'h0000_2000, 1'b0, 1'b1};
    cvec[11] = '{6'd14, 11'h104, 64'h0000_0000_0000_0E0E, 1'b1, 32'h0000_4000, 1'b0, 1'b0};
    cvec[12] = '{6'd9,  11'h555, 64'h9999_9999_9999_9999, 1'b1, 32'h0000_0200, 1'b0, 1'b0};

    // reset state
    #2;
    chk("rst_lkp_ready", lkp_ready_o, 0);
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_ip_valid", ip_valid_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_busy_err", {busy_o, err_o}, 0);
    rst = 1'b1;
    step();
    chk("post_rst_lkp_ready", lkp_ready_o, 1);
    chk("post_rst_cmd_ready", cmd_ready_o, 1);
    chk("post_rst_state", dbg_state_o, 0);

    // lookup path vectors
    for (int i = 0; i < 6; i++) begin
      lkp_valid_i = lvec[i].lkp_valid;
      lkp_ip_i    = lvec[i].lkp_ip;
      step();
      chk("lkp_ip_valid", ip_valid_o, lvec[i].exp_valid);
      chk("lkp_ip_addr", ip_addr_o, lvec[i].exp_addr);
      chk("lkp_wr_en_zero", wr_en_o, 0);
      chk("lkp_ready_idle", lkp_ready_o, 1);
    end
    lkp_valid_i = 1'b0;

    // single lookup, then single-entry batch: must wait out the pipeline
    lkp_valid_i = 1'b1;
    lkp_ip_i    = 32'h0C000001;
    step();
    lkp_valid_i = 1'b0;
    cyc = 0;
    chk("drain_inject", ip_valid_o, 1);
    cmd_valid_i = 1'b1;
    cmd_stage_i = 6'd5;
    cmd_addr_i  = 11'h123;
    cmd_data_i  = 64'hDEADBEEF_00000001;
    cmd_last_i  = 1'b1;
    chk("drain_cmd_ready", cmd_ready_o, 1);
    step();
    cyc = 1;
    cmd_valid_i = 1'b0;
    cmd_last_i  = 1'b0;
    beat  = -1;
    early = 0;
    for (int k = 0; k < 150; k++) begin
      if (wr_en_o != '0) begin
        beat = cyc;
        break;
      end
      if (lkp_ready_o) early++;
      step();
      cyc++;
    end
    chk("drain_beat_seen", beat >= 0, 1);
    chk("drain_beat_not_early", beat >= PL, 1);
    chk("drain_beat_not_late", beat <= PL + 8, 1);
    chk("drain_lkp_blocked", early, 0);
    chk("drain_wr_en", wr_en_o, 32'h0000_0020);
    chk("drain_wr_addr", wr_addr_o, 11'h123);
    chk("drain_wr_data", wr_data_o, 64'hDEADBEEF_00000001);
    chk("drain_back_idle", dbg_state_o, 0);
    step();
    chk("drain_single_beat", wr_en_o, 0);
    chk("drain_not_busy", busy_o, 0);

    // four-entry batch, pipeline idle, with a lookup waiting throughout
    push_cmds(0, 4);
    lkp_valid_i = 1'b1;
    lkp_ip_i    = 32'h0B000001;
    chk("b4_state_drain", dbg_state_o, 1);
    chk("b4_busy_drain", busy_o, 1);
    chk("b4_lkp_blocked", lkp_ready_o, 0);
    step();
    chk("b4_state_write", dbg_state_o, 2);
    chk("b4_no_early_write", wr_en_o, 0);
    step();
    check_beats(0, 4);
    step();
    lkp_valid_i = 1'b0;
    chk("b4_resume_lookup", ip_valid_o, 1);
    chk("b4_resume_addr", ip_addr_o, 32'h0B000001);
    chk("b4_wr_en_done", wr_en_o, 0);

    // overflow: 16 commands, no commit
    for (int i = 0; i < 16; i++) begin
      stg = 6'(i * 2);
      cmd_valid_i = 1'b1;
      cmd_stage_i = stg;
      cmd_addr_i  = 11'(11'h200 + i);
      cmd_data_i  = 64'(i);
      cmd_last_i  = 1'b0;
      chk("ovf_cmd_ready", cmd_ready_o, 1);
      exp_q.push_back({32'h1 << stg, 11'(11'h200 + i)});
      step();
    end
    cmd_valid_i = 1'b0;
    chk("ovf_ready_drop", cmd_ready_o, 0);
    chk("ovf_err_pulse", err_o, 1);
    errs  = 0;
    beats = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (err_o) errs++;
      if (wr_en_o != '0) begin
        beats++;
        if (exp_q.size() > 0) chk("ovf_beat", {wr_en_o, wr_addr_o}, exp_q.pop_front());
        if (exp_q.size() == 0) break;
      end
    end
    chk("ovf_err_once", errs, 0);
    chk("ovf_beat_count", beats, 16);
    step();
    chk("ovf_ready_back", cmd_ready_o, 1);
    chk("ovf_wr_en_done", wr_en_o, 0);

    // batch with an out-of-range stage id
    push_cmds(4, 3);
    wait_beat();
    check_beats(4, 3);
    step();
    chk("bad_stage_done", wr_en_o, 0);

    // reset in the middle of a five-entry batch
    push_cmds(7, 5);
    wait_beat();
    check_beats(7, 2);
    rst = 1'b0;
    #1;
    chk("rst_mid_wr_en", wr_en_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_err", err_o, 0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_lkp_ready", lkp_ready_o, 1);
    chk("rst_mid_cmd_ready", cmd_ready_o, 1);
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      if (wr_en_o != '0 || busy_o) stray++;
      step();
    end
    chk("rst_mid_no_leftover", stray, 0);
    push_cmds(12, 1);
    wait_beat();
    check_beats(12, 1);
    step();
    chk("rst_mid_final_idle", {busy_o, wr_en_o}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sbp_update_sched.md
Name: sbp_update_sched

Overview:
- Sits in front of the scalable pipelined lookup. Admits IP lookups into stage 0 and schedules table-update writes into the per-stage RAMs (port B).
- Update commands are buffered in a FIFO and applied as atomic batches.
- Before a batch is written, lookup admission is paused and in-flight lookups are allowed to drain. No lookup ever sees a half-updated table.

Parameters:
- NUM_STAGES, 32, number of pipeline stages / stage RAMs
- ADDR_BITS, 11, stage RAM address width
- DATA_BITS, 64, stage RAM word width
- STAGE_ID_BITS, 6, width of stage selector in commands
- FIFO_DEPTH, 16, update command buffer entries (power of 2)
- PIPE_LATENCY, 64, cycles from ip_addr_o injection until that lookup has left the last stage RAM read

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- lkp_valid_i  in  1  lookup request valid
- lkp_ip_i  in  32  lookup IP address
- lkp_ready_o  out  1  lookup request accepted when valid&ready
- ip_valid_o  out  1  injected lookup valid, to pipeline stage 0
- ip_addr_o  out  32  injected IP address, to stage 0 ip_addr_i
- cmd_valid_i  in  1  update command valid
- cmd_stage_i  in  STAGE_ID_BITS  target stage
- cmd_addr_i  in  ADDR_BITS  target word address
- cmd_data_i  in  DATA_BITS  word to write
- cmd_last_i  in  1  last command of batch (commit)
- cmd_ready_o  out  1  command accepted when valid&ready
- wr_en_o  out  NUM_STAGES  one-hot port-B write enable per stage RAM
- wr_addr_o  out  ADDR_BITS  broadcast port-B address
- wr_data_o  out  DATA_BITS  broadcast port-B data
- busy_o  out  1  high in DRAIN or WRITE
- err_o  out  1  one-cycle pulse on a protocol error (below)

Behaviour:
- Reset (async assert, sync release): state=IDLE, FIFO empty, commit_pending=0, idle_cnt=PIPE_LATENCY (saturated). All outputs 0 except cmd_ready_o=1 and lkp_ready_o=1, which take those values once the first clock edge follows reset release.
- Lookup path, registered with 1-cycle latency:
  - On accept, ip_valid_o=1 and ip_addr_o=lkp_ip_i on the next cycle.
  - Otherwise ip_valid_o=0 and ip_addr_o holds its last value.
  - lkp_ready_o = (state==IDLE) && !commit_pending.
- idle_cnt:
  - Clears to 0 on any cycle with ip_valid_o=1.
  - Otherwise increments, saturating at PIPE_LATENCY.
- Command path:
  - cmd_ready_o = (state==IDLE) && !commit_pending && FIFO not full.
  - An accepted command is pushed as {stage, addr, data, last}.
  - Accepting a command with cmd_last_i=1 sets commit_pending.
  - If the FIFO becomes full with no last, commit_pending is forced to 1 and err_o pulses once. The batch is then applied partially; software must treat this as overflow.
- FSM:
  - IDLE -> DRAIN: when commit_pending=1.
  - DRAIN: lkp_ready_o=0. Go to WRITE when idle_cnt>=PIPE_LATENCY. If the pipeline is already idle, DRAIN lasts exactly 1 cycle.
  - WRITE: pop one entry per cycle. Next cycle drive wr_en_o[stage]=1 (one-hot), wr_addr_o, wr_data_o (registered, 1-cycle).
    - stage>=NUM_STAGES: wr_en_o stays all-zero for that entry and err_o pulses.
    - When the entry with last=1 is popped, or the FIFO empties, clear commit_pending and go to IDLE.
  - IDLE: lookups resume the cycle after the final write beat. No lookup is injected in the same cycle as any wr_en_o bit.
- Simultaneous events:
  - Lookup and command both valid in IDLE: both may be accepted in the same cycle.
  - Command with last=1 arriving in the same cycle as a lookup: both accepted. The lookup counts toward the drain.
- Commands behind a committed batch are not accepted until the state returns to IDLE. This means a FIFO never holds more than one batch.
- wr_en_o is all-zero in every state except during WRITE beats. wr_addr_o and wr_data_o hold their last value otherwise.
- Reset mid-operation: the FIFO and batch are discarded, no further wr_en_o, and all state returns to reset values immediately.

Test Plan:
- Reset then 3 lookups 0x0A000001..3 back-to-back -> ip_valid_o high 3 cycles, starting 1 cycle after accept, with matching addresses; wr_en_o=0 throughout.
- Lookup at cycle 0, then batch {stage 5, addr 0x123, data 0xDEADBEEF_00000001, last} -> lkp_ready_o=0 until 64 cycles after injection; then exactly one beat wr_en_o=1<<5, addr 0x123, data matches; then IDLE.
- Batch of 4 commands, stages 0,1,31,2, last on 4th, pipeline idle -> DRAIN 1 cycle, 4 consecutive one-hot beats in order; no ip_valid_o during writes; busy_o high for DRAIN+WRITE.
- 16 commands without last (FIFO_DEPTH=16) -> cmd_ready_o drops after the 16th; err_o pulses once; 16 write beats follow.
- Command with stage 40 inside a batch -> that beat has wr_en_o=0 and err_o pulses; the other entries are written normally.
- Assert rst low mid-WRITE after 2 of 5 beats -> wr_en_o=0 immediately; after release the FIFO is empty, lkp_ready_o=1 and cmd_ready_o=1.
